lsu_cache_req: RTL and testbench
================================

# lsu_cache_req

Core-side load/store requester that drives the cache request interface (`cache_re`/`cache_we`/addresses/`cache_access_sz`) and consumes `cache_rdata`/`cache_hit`. It is the initiator end of the interface served by the cache.

- Accepts one memory op at a time from the EX/MEM pipeline over a valid/ready handshake.
- Checks alignment.
- Issues the access, waits for `cache_hit`, then lane-extracts and sign- or zero-extends load data.
- Returns the result to WB over a second valid/ready handshake.

## Interface

Parameters:
- `WAIT_MAX`, default 255: maximum WAIT cycles before a bus-error response is generated.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high together with `req_valid`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (low bytes significant).
- `req_sz`  in  3  `ACCESS_SZ_WORD`/`HALF`/`BYTE`.
- `req_signed`  in  1  sign-extend load result.
- `req_rd`  in  5  destination register tag, passed through.
- `cache_re`  out  1  read request.
- `cache_raddr`  out  32  read address.
- `cache_we`  out  1  write request.
- `cache_waddr`  out  32  write address.
- `cache_wdata`  out  32  store data, unshifted; the cache replicates lanes.
- `cache_access_sz`  out  3  access size.
- `cache_rdata`  in  32  full word at the word-aligned address.
- `cache_hit`  in  1  access complete / `cache_rdata` valid.
- `resp_valid`  out  1  result present.
- `resp_ready`  in  1  WB consumes result.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_rd`  out  5  tag of completed op.
- `resp_is_load`  out  1  op was a load.
- `resp_ale`  out  1  address-misaligned exception.
- `resp_berr`  out  1  wait timeout.
- `resp_badv`  out  32  faulting address; valid when `resp_ale` or `resp_berr` is set.

## Operation

State machine with states IDLE, REQ, WAIT and RESP.

IDLE:
- `req_ready` = 1.
- On handshake, latch `addr`, `wdata`, `sz`, `we`, `signed` and `rd`.
- If misaligned, go to RESP with `ale` = 1 and no cache access. Misaligned means HALF with `addr[0]` = 1, or WORD with `addr[1:0]` ≠ 0.
- An unknown `sz` encoding is also treated as `ale`.
- Otherwise go to REQ.

REQ, exactly 1 cycle:
- Assert `cache_re` (load) or `cache_we` (store).
- `cache_raddr` = `cache_waddr` = latched address.
- `cache_access_sz` = latched size.
- Go to WAIT.

WAIT:
- `cache_re` and `cache_we` are 0; addresses and size stay held.
- Wait counter clears on entry to WAIT.
- When `cache_hit` = 1, capture `cache_rdata` and go to RESP.
- Otherwise increment the counter. At counter = `WAIT_MAX`, go to RESP with `berr` = 1.

RESP:
- `resp_valid` = 1; outputs hold stable until `resp_ready`.
- On `resp_ready`, if `req_valid` is also high, `req_ready` = 1 and the new request is accepted (back-to-back). It goes to REQ or RESP following the IDLE rules. Otherwise go to IDLE.

Load extraction, with `o` = `addr[1:0]`:
- BYTE: byte lane = `rdata[8*o+7 : 8*o]`.
- HALF: lane = `rdata[16*o[1]+15 : 16*o[1]]`.
- WORD: whole word.
- The extracted value is extended to 32 bits: sign-extended if `signed`, else zero-extended.

Faulted ops (`ale` or `berr`) return `resp_rdata` = 0.

## Timing

- All outputs derive from registered state and latched fields. There is no combinational path from `req_*` to `cache_*`.
- `req_ready` depends only on the state and on `resp_ready`.
- Aligned op: handshake at edge 0, REQ in cycle 1, WAIT in cycle 2. `cache_hit` in cycle 2 gives RESP in cycle 3. Minimum latency is 3 cycles.
- The data-capture cycle follows the request cycle, which matches a synchronous SRAM behind the cache.
- Misaligned op: RESP in cycle 1.
- Sustained throughput: one aligned op per 3 cycles when `resp_ready` is held high.
- Reset (`rst_n` = 0 at an edge) returns the block to IDLE in any state. After reset:
  - `req_ready` = 1.
  - `cache_re`, `cache_we` and `resp_valid` = 0.
  - Addresses, `wdata`, `rdata`, `badv` and `rd` = 0.
  - `sz` = 0.
  - The `ale`, `berr` and `is_load` flags = 0.
  - The wait counter = 0.
- A store already issued in REQ is not retracted by reset.
- `cache_hit` in REQ is ignored; only hit in WAIT counts.
- Wait counter width: `$clog2(WAIT_MAX+1)`, saturating; no wrap.

## Structure

- The `ACCESS_SZ_*` encodings come from the shared `defs.v`. Add `LSU_ST_IDLE`, `LSU_ST_REQ`, `LSU_ST_WAIT` and `LSU_ST_RESP` there as 2-bit encodings.
- One sub-module, `load_align`: purely combinational extractor with inputs (`rdata`, `offset[1:0]`, `sz`, `signed`) and output `rdata_ext[31:0]`. It is reused later by the uncached path.

## Test plan

- Word load at 0x1000, cache returns 0xDEADBEEF with hit in the cycle after REQ: `resp_valid` in cycle 3, `resp_rdata` = 0xDEADBEEF, `resp_is_load` = 1.
- Signed byte load at 0x1003, `rdata` 0x80FF_0000: `resp_rdata` = 0xFFFFFF80. Unsigned byte at 0x1002: 0x000000FF. Signed half at 0x1002: 0xFFFF80FF.
- Half store at 0x2001: no `cache_we` ever asserted; RESP in cycle 1 with `resp_ale` = 1 and `resp_badv` = 0x2001. Word load at 0x2002: same behaviour.
- Byte store of 0xA5 at 0x3002: `cache_we` high for exactly 1 cycle, `cache_waddr` = 0x3002, `cache_wdata[7:0]` = 0xA5, size BYTE. Response has `resp_rdata` = 0 and `resp_is_load` = 0.
- Hold `cache_hit` = 0 with `WAIT_MAX` = 4: RESP after 4 WAIT cycles with `resp_berr` = 1. Then hold `resp_ready` = 0 for 3 cycles: outputs stable; a back-to-back request is accepted on the `resp_ready` cycle.
- Assert `rst_n` = 0 during WAIT: next cycle IDLE with all outputs at reset values. A following request completes normally.

Source files
------------

// File: rtl/lsu_cache_req_pkg.sv
// Shared encodings for the LSU cache requester: access sizes, FSM states
// and the alignment rule used when a request is accepted.
package lsu_cache_req_pkg;

    localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
    localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
    localparam logic [2:0] ACCESS_SZ_WORD = 3'd2;

    typedef enum logic [1:0] {
        LSU_ST_IDLE = 2'd0,
        LSU_ST_REQ  = 2'd1,
        LSU_ST_WAIT = 2'd2,
        LSU_ST_RESP = 2'd3
    } lsu_state_e;

    // Unknown size encodings count as misaligned so they never reach the cache.
    function automatic logic is_misaligned(input logic [2:0] sz, input logic [1:0] off);
        logic mis;
        case (sz)
            ACCESS_SZ_BYTE: mis = 1'b0;
            ACCESS_SZ_HALF: mis = off[0];
            ACCESS_SZ_WORD: mis = (off != 2'b00);
            default:        mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_cache_req_load_align.sv
// load_align: picks the addressed byte/half lane out of a full cache word
// and sign- or zero-extends it. Purely combinational; shared with the
// uncached load path.
module load_align
    import lsu_cache_req_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  sz,
    input  logic        is_signed,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension; unknown sizes pass the word through.
    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        case (sz)
            ACCESS_SZ_BYTE: rdata_ext = {{24{is_signed & byte_lane[7]}}, byte_lane};
            ACCESS_SZ_HALF: rdata_ext = {{16{is_signed & half_lane[15]}}, half_lane};
            default:        rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_cache_req.sv
// lsu_cache_req: single-outstanding load/store requester on the cache
// interface. Accepts an op, checks alignment, issues a one-cycle request,
// waits (bounded) for cache_hit and returns the extended result to WB.
module lsu_cache_req
    import lsu_cache_req_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // request from EX/MEM
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_sz,
    input  logic        req_signed,
    input  logic [4:0]  req_rd,
    // cache interface
    output logic        cache_re,
    output logic [31:0] cache_raddr,
    output logic        cache_we,
    output logic [31:0] cache_waddr,
    output logic [31:0] cache_wdata,
    output logic [2:0]  cache_access_sz,
    input  logic [31:0] cache_rdata,
    input  logic        cache_hit,
    // response to WB
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_is_load,
    output logic        resp_ale,
    output logic        resp_berr,
    output logic [31:0] resp_badv
);

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_MAX_C = CW'(WAIT_MAX);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] badv_q, badv_d;
    logic [2:0]  sz_q, sz_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic        signed_q, signed_d;
    logic        is_load_q, is_load_d;
    logic        ale_q, ale_d;
    logic        berr_q, berr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [CW-1:0] cnt_inc;
    logic          accept;
    logic [31:0]   rdata_ext;

    // State and latched-field registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= LSU_ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            badv_q    <= '0;
            sz_q      <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            is_load_q <= 1'b0;
            ale_q     <= 1'b0;
            berr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            badv_q    <= badv_d;
            sz_q      <= sz_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            signed_q  <= signed_d;
            is_load_q <= is_load_d;
            ale_q     <= ale_d;
            berr_q    <= berr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic; a new op may be accepted from IDLE or from RESP
    // in the same cycle the previous result is consumed.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        badv_d    = badv_q;
        sz_d      = sz_q;
        rd_d      = rd_q;
        we_d      = we_q;
        signed_d  = signed_q;
        is_load_d = is_load_q;
        ale_d     = ale_q;
        berr_d    = berr_q;
        cnt_d     = cnt_q;

        cnt_inc   = (cnt_q == WAIT_MAX_C) ? cnt_q : cnt_q + CW'(1);
        req_ready = (state_q == LSU_ST_IDLE) ||
                    ((state_q == LSU_ST_RESP) && resp_ready);
        accept    = req_valid && req_ready;

        case (state_q)
            LSU_ST_IDLE: ;
            LSU_ST_REQ: begin
                // cache_hit here is ignored; the data arrives a cycle later.
                state_d = LSU_ST_WAIT;
                cnt_d   = '0;
            end
            LSU_ST_WAIT: begin
                if (cache_hit) begin
                    rdata_d = cache_rdata;
                    state_d = LSU_ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == WAIT_MAX_C) begin
                        berr_d  = 1'b1;
                        badv_d  = addr_q;
                        state_d = LSU_ST_RESP;
                    end
                end
            end
            LSU_ST_RESP: begin
                if (resp_ready) state_d = LSU_ST_IDLE;
            end
            default: state_d = LSU_ST_IDLE;
        endcase

        if (accept) begin
            addr_d    = req_addr;
            wdata_d   = req_wdata;
            sz_d      = req_sz;
            rd_d      = req_rd;
            we_d      = req_we;
            signed_d  = req_signed;
            is_load_d = ~req_we;
            rdata_d   = '0;
            berr_d    = 1'b0;
            cnt_d     = '0;
            if (is_misaligned(req_sz, req_addr[1:0])) begin
                ale_d   = 1'b1;
                badv_d  = req_addr;
                state_d = LSU_ST_RESP;
            end else begin
                ale_d   = 1'b0;
                badv_d  = '0;
                state_d = LSU_ST_REQ;
            end
        end
    end

    load_align u_load_align (
        .rdata     (rdata_q),
        .offset    (addr_q[1:0]),
        .sz        (sz_q),
        .is_signed (signed_q),
        .rdata_ext (rdata_ext)
    );

    // Cache side: request strobes only in REQ, address/size held from latch.
    assign cache_re        = (state_q == LSU_ST_REQ) && is_load_q;
    assign cache_we        = (state_q == LSU_ST_REQ) && we_q;
    assign cache_raddr     = addr_q;
    assign cache_waddr     = addr_q;
    assign cache_wdata     = wdata_q;
    assign cache_access_sz = sz_q;

    // WB side: stores and faulted ops return zero data.
    assign resp_valid   = (state_q == LSU_ST_RESP);
    assign resp_rdata   = (ale_q || berr_q || we_q) ? 32'd0 : rdata_ext;
    assign resp_rd      = rd_q;
    assign resp_is_load = is_load_q;
    assign resp_ale     = ale_q;
    assign resp_berr    = berr_q;
    assign resp_badv    = badv_q;

endmodule

// File: tb/tb_lsu_cache_req.sv
// Directed bench for lsu_cache_req with WAIT_MAX = 4.
module tb_lsu_cache_req;
    import lsu_cache_req_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_sz;
    logic [4:0]  req_rd;
    logic        cache_re, cache_we, cache_hit;
    logic [31:0] cache_raddr, cache_waddr, cache_wdata, cache_rdata;
    logic [2:0]  cache_access_sz;
    logic        resp_valid, resp_ready, resp_is_load, resp_ale, resp_berr;
    logic [31:0] resp_rdata, resp_badv;
    logic [4:0]  resp_rd;

    int checks = 0;
    int errors = 0;

    lsu_cache_req #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sz(req_sz),
        .req_signed(req_signed), .req_rd(req_rd),
        .cache_re(cache_re), .cache_raddr(cache_raddr), .cache_we(cache_we),
        .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
        .cache_access_sz(cache_access_sz), .cache_rdata(cache_rdata),
        .cache_hit(cache_hit),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_is_load(resp_is_load), .resp_ale(resp_ale),
        .resp_berr(resp_berr), .resp_badv(resp_badv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one op and let it handshake on the next edge.
    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] sz, input logic sg, input logic [4:0] rd);
        req_we = we; req_addr = a; req_wdata = wd; req_sz = sz;
        req_signed = sg; req_rd = rd; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if ({cache_re, cache_we, resp_valid} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {cache_re, cache_we, resp_valid}); end
        checks++; if ({cache_raddr, cache_waddr, cache_wdata, resp_badv} !== 128'd0) begin errors++; $display("FAIL reset_addr_data got %h exp 0", {cache_raddr, cache_waddr, cache_wdata, resp_badv}); end
        checks++; if ({cache_access_sz, resp_rd, resp_ale, resp_berr, resp_is_load, resp_rdata} !== 43'd0) begin errors++; $display("FAIL reset_flags got %h exp 0", {cache_access_sz, resp_rd, resp_ale, resp_berr, resp_is_load, resp_rdata}); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_word_load();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wl_ready got %b exp 1", req_ready); end
        issue(1'b0, 32'h1000, 32'h0, ACCESS_SZ_WORD, 1'b0, 5'd7);
        // cycle 1: REQ
        checks++; if ({cache_re, cache_we} !== 2'b10) begin errors++; $display("FAIL wl_req_strobes got %b exp 10", {cache_re, cache_we}); end
        checks++; if (cache_raddr !== 32'h1000 || cache_access_sz !== ACCESS_SZ_WORD) begin errors++; $display("FAIL wl_req_addr got %h/%0d exp 1000/%0d", cache_raddr, cache_access_sz, ACCESS_SZ_WORD); end
        cyc();
        // cycle 2: WAIT, hit arrives
        checks++; if ({cache_re, resp_valid} !== 2'b00) begin errors++; $display("FAIL wl_wait got %b exp 00", {cache_re, resp_valid}); end
        checks++; if (cache_raddr !== 32'h1000) begin errors++; $display("FAIL wl_wait_addr got %h exp 1000", cache_raddr); end
        cache_hit = 1'b1; cache_rdata = 32'hDEADBEEF;
        cyc();
        cache_hit = 1'b0; cache_rdata = 32'h0;
        // cycle 3: RESP
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wl_resp_valid got %b exp 1", resp_valid); end
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_rdata got %h exp deadbeef", resp_rdata); end
        checks++; if ({resp_is_load, resp_ale, resp_berr, resp_rd} !== {3'b100, 5'd7}) begin errors++; $display("FAIL wl_flags got %b exp 10000111", {resp_is_load, resp_ale, resp_berr, resp_rd}); end
        consume();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wl_idle got %b%b exp 01", resp_valid, req_ready); end
    endtask

    // Sub-word loads; hit is also raised during REQ to show it is ignored there.
    task automatic test_subword_loads();
        logic [31:0] a [3];
        logic [2:0]  s [3];
        logic        g [3];
        logic [31:0] e [3];
        a[0] = 32'h1003; s[0] = ACCESS_SZ_BYTE; g[0] = 1'b1; e[0] = 32'hFFFFFF80;
        a[1] = 32'h1002; s[1] = ACCESS_SZ_BYTE; g[1] = 1'b0; e[1] = 32'h000000FF;
        a[2] = 32'h1002; s[2] = ACCESS_SZ_HALF; g[2] = 1'b1; e[2] = 32'hFFFF80FF;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, a[i], 32'h0, s[i], g[i], 5'd3);
            checks++; if (cache_re !== 1'b1 || cache_access_sz !== s[i]) begin errors++; $display("FAIL sub%0d_req got re=%b sz=%0d exp 1/%0d", i, cache_re, cache_access_sz, s[i]); end
            cache_hit = 1'b1; cache_rdata = 32'h80FF0000;
            cyc();
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sub%0d_hit_in_req got resp_valid %b exp 0", i, resp_valid); end
            cyc();
            cache_hit = 1'b0; cache_rdata = 32'h0;
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== e[i]) begin errors++; $display("FAIL sub%0d_rdata got %b/%h exp 1/%h", i, resp_valid, resp_rdata, e[i]); end
            consume();
        end
    endtask

    task automatic test_misaligned();
        int ncache;
        // half store at odd address
        issue(1'b1, 32'h2001, 32'h1234, ACCESS_SZ_HALF, 1'b0, 5'd1);
        ncache = int'(cache_we) + int'(cache_re);
        checks++; if ({resp_valid, resp_ale, resp_berr} !== 3'b110) begin errors++; $display("FAIL mis_hs_flags got %b exp 110", {resp_valid, resp_ale, resp_berr}); end
        checks++; if (resp_badv !== 32'h2001 || resp_rdata !== 32'h0) begin errors++; $display("FAIL mis_hs_badv got %h/%h exp 2001/0", resp_badv, resp_rdata); end
        consume();
        ncache += int'(cache_we) + int'(cache_re);
        cyc();
        ncache += int'(cache_we) + int'(cache_re);
        checks++; if (ncache != 0) begin errors++; $display("FAIL mis_hs_no_cache got %0d strobes exp 0", ncache); end
        // word load at half-aligned address
        issue(1'b0, 32'h2002, 32'h0, ACCESS_SZ_WORD, 1'b0, 5'd2);
        checks++; if ({resp_valid, resp_ale, cache_re} !== 3'b110 || resp_badv !== 32'h2002) begin errors++; $display("FAIL mis_wl got %b/%h exp 110/2002", {resp_valid, resp_ale, cache_re}, resp_badv); end
        consume();
        // unknown size encoding at aligned address
        issue(1'b0, 32'h2000, 32'h0, 3'd5, 1'b0, 5'd2);
        checks++; if ({resp_valid, resp_ale, cache_re} !== 3'b110 || resp_badv !== 32'h2000) begin errors++; $display("FAIL mis_badsz got %b/%h exp 110/2000", {resp_valid, resp_ale, cache_re}, resp_badv); end
        consume();
    endtask

    task automatic test_store();
        int nwe;
        issue(1'b1, 32'h3002, 32'h000000A5, ACCESS_SZ_BYTE, 1'b0, 5'd4);
        nwe = int'(cache_we);
        checks++; if (cache_we !== 1'b1 || cache_re !== 1'b0) begin errors++; $display("FAIL st_req got we=%b re=%b exp 1/0", cache_we, cache_re); end
        checks++; if (cache_waddr !== 32'h3002 || cache_wdata[7:0] !== 8'hA5 || cache_access_sz !== ACCESS_SZ_BYTE) begin errors++; $display("FAIL st_fields got %h/%h/%0d exp 3002/a5/%0d", cache_waddr, cache_wdata[7:0], cache_access_sz, ACCESS_SZ_BYTE); end
        cyc();
        nwe += int'(cache_we);
        cache_hit = 1'b1; cache_rdata = 32'h55667788;
        cyc();
        nwe += int'(cache_we);
        cache_hit = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_is_load !== 1'b0) begin errors++; $display("FAIL st_resp got %b/%h/%b exp 1/0/0", resp_valid, resp_rdata, resp_is_load); end
        consume();
        nwe += int'(cache_we);
        checks++; if (nwe != 1) begin errors++; $display("FAIL st_we_cycles got %0d exp 1", nwe); end
    endtask

    task automatic test_timeout_backpressure();
        int k;
        logic found;
        issue(1'b0, 32'h4000, 32'h0, ACCESS_SZ_WORD, 1'b0, 5'd9);
        // handshake edge already taken: now in cycle 1; RESP expected in cycle 6
        k = 1; found = 1'b0;
        while (!found && k < 20) begin
            if (resp_valid === 1'b1) found = 1'b1;
            else begin cyc(); k++; end
        end
        checks++; if (!found || k != 6) begin errors++; $display("FAIL to_latency got found=%b cycle %0d exp cycle 6", found, k); end
        checks++; if (resp_berr !== 1'b1 || resp_ale !== 1'b0 || resp_badv !== 32'h4000 || resp_rdata !== 32'h0) begin errors++; $display("FAIL to_flags got berr=%b ale=%b badv=%h rdata=%h exp 1/0/4000/0", resp_berr, resp_ale, resp_badv, resp_rdata); end
        // stall WB for 3 cycles with a new request waiting
        req_we = 1'b0; req_addr = 32'h5000; req_sz = ACCESS_SZ_WORD; req_signed = 1'b0; req_rd = 5'd10; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_berr !== 1'b1 || resp_badv !== 32'h4000 || resp_rd !== 5'd9) begin errors++; $display("FAIL to_hold%0d got rdy=%b v=%b berr=%b badv=%h rd=%0d", i, req_ready, resp_valid, resp_berr, resp_badv, resp_rd); end
            cyc();
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", req_ready); end
        cyc();
        req_valid = 1'b0; resp_ready = 1'b0;
        checks++; if (cache_re !== 1'b1 || cache_raddr !== 32'h5000 || resp_valid !== 1'b0 || resp_berr !== 1'b0) begin errors++; $display("FAIL b2b_req got re=%b addr=%h v=%b berr=%b", cache_re, cache_raddr, resp_valid, resp_berr); end
        cyc();
        cache_hit = 1'b1; cache_rdata = 32'h12345678;
        cyc();
        cache_hit = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678 || resp_rd !== 5'd10 || resp_berr !== 1'b0) begin errors++; $display("FAIL b2b_resp got v=%b rdata=%h rd=%0d berr=%b", resp_valid, resp_rdata, resp_rd, resp_berr); end
        consume();
    endtask

    task automatic test_reset_in_wait();
        issue(1'b0, 32'h6004, 32'h0, ACCESS_SZ_WORD, 1'b0, 5'd12);
        cyc();
        // in WAIT now
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++; if (req_ready !== 1'b1 || {cache_re, cache_we, resp_valid} !== 3'b000) begin errors++; $display("FAIL rw_ctrl got rdy=%b strobes=%b exp 1/000", req_ready, {cache_re, cache_we, resp_valid}); end
        checks++; if ({cache_raddr, cache_waddr, resp_badv} !== 96'd0 || {cache_access_sz, resp_rd, resp_is_load, resp_ale, resp_berr} !== 11'd0) begin errors++; $display("FAIL rw_fields got %h sz=%0d rd=%0d", cache_raddr, cache_access_sz, resp_rd); end
        issue(1'b0, 32'h6004, 32'h0, ACCESS_SZ_WORD, 1'b0, 5'd12);
        cyc();
        cache_hit = 1'b1; cache_rdata = 32'hCAFEF00D;
        cyc();
        cache_hit = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D || resp_rd !== 5'd12) begin errors++; $display("FAIL rw_after got v=%b rdata=%h rd=%0d exp 1/cafef00d/12", resp_valid, resp_rdata, resp_rd); end
        consume();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_sz = '0; req_signed = 1'b0; req_rd = '0; cache_rdata = '0; cache_hit = 1'b0;
        resp_ready = 1'b0;
        #2;
        test_reset();
        test_word_load();
        test_subword_loads();
        test_misaligned();
        test_store();
        test_timeout_backpressure();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
